// File: rtl/mmio_sched_pkg.sv
// ============================================================================
// Module  : mmio_sched_pkg
// Brief   : CCI-P MMIO channel types, read-request record and scheduler states.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mmio_sched_pkg;

    typedef logic [8:0] t_ccip_tid;

    typedef struct packed {
        logic [15:0] address;
        logic [1:0]  length;
        logic        rsvd;
        t_ccip_tid   tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        logic [511:0]        data;
        logic                rspValid;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_tid tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_ccip_tid   tid;
        logic [15:0] address;
    } t_mmio_rd_req;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } t_sched_state;

    localparam logic [63:0] MMIO_TMO_DATA = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MMIO_OOR_DATA = 64'h0;

endpackage

`default_nettype wire

// File: rtl/mmio_req_fifo.sv
// ============================================================================
// Module  : mmio_req_fifo
// Brief   : Synchronous FIFO of MMIO read requests; wrap-bit pointers, a pop
//           frees its slot for a same-cycle push when full.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mmio_req_fifo
    import mmio_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  t_mmio_rd_req din,
    input  logic         pop,
    output t_mmio_rd_req dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    t_mmio_rd_req   r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic           w_do_push;
    logic           w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // Storage carries no reset; only pointer state defines occupancy.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/mmio_rsp_sched.sv
// ============================================================================
// Module  : mmio_rsp_sched
// Brief   : CCI-P MMIO owner: decodes c0 Rx reads/writes to CSR slaves,
//           serialises reads with a timeout, drives c2 Tx read responses.
//           Optional counters: MMIO_RSP_SCHED_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mmio_rsp_sched
    import mmio_sched_pkg::*;
#(
    parameter int N_SLV    = 4,
    parameter int SEL_W    = 4,
    parameter int RQ_DEPTH = 8,
    parameter int TIMEOUT  = 48
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  t_if_ccip_c0_Rx       rx,
    output t_if_ccip_c2_Tx       tx,
    output logic [N_SLV-1:0]     slv_rd_valid,
    output logic [N_SLV-1:0]     slv_wr_valid,
    output logic [15:0]          slv_addr,
    output logic [63:0]          slv_wdata,
    input  logic [N_SLV-1:0]     slv_rd_ack,
    input  logic [N_SLV*64-1:0]  slv_rd_data
`ifdef MMIO_RSP_SCHED_STATS_EN
    ,
    output logic [15:0]          stat_ovf_cnt,
    output logic [15:0]          stat_tmo_cnt
`endif
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    t_sched_state       r_state;
    t_sched_state       w_state_nxt;
    t_mmio_rd_req       w_q_din;
    t_mmio_rd_req       w_q_head;
    logic               w_q_full;
    logic               w_q_empty;
    logic               w_q_push;
    logic               w_q_pop;
    logic [SEL_W-1:0]   w_rx_sel;
    logic [SEL_W-1:0]   w_head_sel;
    logic               w_rx_in_range;
    logic               w_head_in_range;
    logic               w_wr_hit;
    logic               w_ack;
    logic               w_tmo_hit;
    logic [63:0]        w_ack_data;
    logic [N_SLV-1:0]   r_sel_oh;
    t_ccip_tid          r_tid;
    logic [63:0]        r_data;
    logic [TW-1:0]      r_wait_cnt;
    logic [N_SLV-1:0]   r_slv_rd_valid;
    logic [N_SLV-1:0]   r_slv_wr_valid;
    logic [15:0]        r_slv_addr;
    logic [63:0]        r_slv_wdata;
    logic               w_unused;

    assign w_rx_sel        = rx.hdr.address[15 -: SEL_W];
    assign w_head_sel      = w_q_head.address[15 -: SEL_W];
    assign w_rx_in_range   = {{(32-SEL_W){1'b0}}, w_rx_sel} < 32'(N_SLV);
    assign w_head_in_range = {{(32-SEL_W){1'b0}}, w_head_sel} < 32'(N_SLV);
    assign w_wr_hit        = rx.mmioWrValid && w_rx_in_range;

    // A write wins over a simultaneous read, so the read is never queued.
    assign w_q_push    = rx.mmioRdValid && !rx.mmioWrValid;
    assign w_q_din.tid = rx.hdr.tid;
    assign w_q_din.address = rx.hdr.address;

    mmio_req_fifo #(
        .DEPTH (RQ_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_q_push),
        .din   (w_q_din),
        .pop   (w_q_pop),
        .dout  (w_q_head),
        .full  (w_q_full),
        .empty (w_q_empty)
    );

    assign w_ack = |(slv_rd_ack & r_sel_oh);

    always_comb begin
        w_ack_data = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (r_sel_oh[i]) w_ack_data = w_ack_data | slv_rd_data[64*i +: 64];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Pop is held off while a write strobes so read and write never share slv_addr.
    always_comb begin
        w_state_nxt = r_state;
        w_q_pop     = 1'b0;
        w_tmo_hit   = 1'b0;
        tx          = '0;
        case (r_state)
            IDLE: begin
                if (!w_q_empty && !rx.mmioWrValid) begin
                    w_q_pop     = 1'b1;
                    w_state_nxt = w_head_in_range ? ISSUE : RESP;
                end
            end
            ISSUE: w_state_nxt = WAIT;
            WAIT: begin
                if (w_ack) begin
                    w_state_nxt = RESP;
                end else if (r_wait_cnt == TW'(TIMEOUT - 1)) begin
                    w_tmo_hit   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                tx.mmioRdValid = 1'b1;
                tx.hdr.tid     = r_tid;
                tx.data        = r_data;
                w_state_nxt    = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slv_rd_valid <= '0;
            r_slv_wr_valid <= '0;
            r_slv_addr     <= '0;
            r_slv_wdata    <= '0;
            r_sel_oh       <= '0;
            r_tid          <= '0;
            r_data         <= '0;
            r_wait_cnt     <= '0;
        end else begin
            r_slv_rd_valid <= '0;
            r_slv_wr_valid <= '0;
            if (w_wr_hit) begin
                r_slv_wr_valid <= N_SLV'(1) << w_rx_sel;
                r_slv_addr     <= rx.hdr.address;
                r_slv_wdata    <= rx.data[63:0];
            end
            if (w_q_pop) begin
                r_tid    <= w_q_head.tid;
                r_sel_oh <= N_SLV'(1) << w_head_sel;
                r_data   <= MMIO_OOR_DATA;
                if (w_head_in_range) begin
                    r_slv_rd_valid <= N_SLV'(1) << w_head_sel;
                    r_slv_addr     <= w_q_head.address;
                end
            end
            if (r_state == ISSUE)     r_wait_cnt <= '0;
            else if (r_state == WAIT) r_wait_cnt <= r_wait_cnt + TW'(1);
            if (r_state == WAIT && w_ack) r_data <= w_ack_data;
            else if (w_tmo_hit)           r_data <= MMIO_TMO_DATA;
        end
    end

    assign slv_rd_valid = r_slv_rd_valid;
    assign slv_wr_valid = r_slv_wr_valid;
    assign slv_addr     = r_slv_addr;
    assign slv_wdata    = r_slv_wdata;

`ifdef MMIO_RSP_SCHED_STATS_EN
    logic        w_rd_drop;
    logic [15:0] r_ovf_cnt;
    logic [15:0] r_tmo_cnt;

    assign w_rd_drop = rx.mmioRdValid && (rx.mmioWrValid || (w_q_full && !w_q_pop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_cnt <= '0;
            r_tmo_cnt <= '0;
        end else begin
            if (w_rd_drop && r_ovf_cnt != 16'hFFFF) r_ovf_cnt <= r_ovf_cnt + 16'd1;
            if (w_tmo_hit && r_tmo_cnt != 16'hFFFF) r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end

    assign stat_ovf_cnt = r_ovf_cnt;
    assign stat_tmo_cnt = r_tmo_cnt;
    assign w_unused     = ^{rx.rspValid, rx.hdr.length, rx.hdr.rsvd, rx.data[511:64]};
`else
    assign w_unused     = ^{rx.rspValid, rx.hdr.length, rx.hdr.rsvd, rx.data[511:64], w_q_full};
`endif

endmodule

`default_nettype wire
